// File: rtl/cr_sa_counter_bank.sv
// Statistics-aggregation counter bank: per-counter event select, enable, wrap/saturate,
// sticky overflow, read-with-clear and an atomic bank-wide snapshot / snap-and-clear.
module cr_sa_counter_bank #(
  parameter int N_CNT = 64,
  parameter int CNT_W = 50,
  parameter int N_EVT = 128,
  parameter int SEL_W = 7,
  parameter int IDX_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_EVT-1:0]         stat_events,
  input  logic [N_CNT*SEL_W-1:0]   cfg_sel,
  input  logic [N_CNT-1:0]         cfg_en,
  input  logic [N_CNT-1:0]         cfg_sat,
  input  logic                     snap_req,
  input  logic                     clear_live,
  input  logic                     rd_req,
  input  logic [IDX_W-1:0]         rd_idx,
  input  logic                     rd_snap,
  input  logic                     rd_clr,
  input  logic [N_CNT-1:0]         ovf_clr,
  output logic                     rd_ack,
  output logic [CNT_W-1:0]         rd_data,
  output logic [N_CNT-1:0]         ovf_flags,
  output logic                     ovf_irq
);

  localparam int EXT_W = 2 ** SEL_W;

  logic [N_EVT-1:0] ev_q;
  logic [CNT_W-1:0] cnt_q  [N_CNT];
  logic [CNT_W-1:0] cnt_d  [N_CNT];
  logic [CNT_W-1:0] snap_q [N_CNT];
  logic [CNT_W:0]   inc    [N_CNT];
  logic [N_CNT-1:0] hit;
  logic [N_CNT-1:0] rclr;
  logic [N_CNT-1:0] ovf_set;
  logic [N_CNT-1:0] ovf_flags_q;
  logic [EXT_W-1:0] ev_ext;
  logic [CNT_W-1:0] rd_data_d;
  logic [CNT_W-1:0] rd_data_q;
  logic             rd_ack_q;
  logic             ovf_irq_q;

  // Returns {overflow, next value} for a +1 step in wrap or saturate mode.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v, input logic sat);
    logic [CNT_W:0] r;
    if (&v) r = {1'b1, (sat ? v : {CNT_W{1'b0}})};
    else    r = {1'b0, v + CNT_W'(1)};
    return r;
  endfunction

  // Stage 1: registered events -> per-counter next state and read mux
  always_comb begin
    ev_ext    = '0;
    ev_ext[N_EVT-1:0] = ev_q;
    hit       = '0;
    rclr      = '0;
    ovf_set   = '0;
    rd_data_d = '0;
    for (int i = 0; i < N_CNT; i++) begin
      // Zero-extended event vector makes out-of-range selects read as no event.
      hit[i]   = cfg_en[i] & ev_ext[cfg_sel[i*SEL_W +: SEL_W]];
      rclr[i]  = rd_req & rd_clr & ~rd_snap & (rd_idx == IDX_W'(i));
      inc[i]   = bump(cnt_q[i], cfg_sat[i]);
      cnt_d[i] = cnt_q[i];
      if (clear_live) begin
        cnt_d[i] = '0;
      end else if (rclr[i]) begin
        cnt_d[i] = CNT_W'(hit[i]);
      end else if (hit[i]) begin
        cnt_d[i]   = inc[i][CNT_W-1:0];
        ovf_set[i] = inc[i][CNT_W];
      end
      if (rd_idx == IDX_W'(i)) rd_data_d = rd_snap ? snap_q[i] : cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_q        <= '0;
      ovf_flags_q <= '0;
      ovf_irq_q   <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= '0;
      for (int i = 0; i < N_CNT; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      ev_q        <= stat_events;
      ovf_flags_q <= ovf_set | (ovf_flags_q & ~ovf_clr);
      ovf_irq_q   <= |ovf_flags_q;
      rd_ack_q    <= rd_req;
      if (rd_req) rd_data_q <= rd_data_d;
      for (int i = 0; i < N_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (snap_req) snap_q[i] <= cnt_q[i];
      end
    end
  end

  assign rd_ack    = rd_ack_q;
  assign rd_data   = rd_data_q;
  assign ovf_flags = ovf_flags_q;
  assign ovf_irq   = ovf_irq_q;

endmodule

// File: tb/tb_cr_sa_counter_bank.sv
// Directed bench for cr_sa_counter_bank built with N_CNT=40, CNT_W=8, N_EVT=100.
module tb_cr_sa_counter_bank;

  localparam int NC = 40;
  localparam int CW = 8;
  localparam int NE = 100;
  localparam int SW = 7;
  localparam int IW = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NE-1:0]     stat_events = '0;
  logic [NC*SW-1:0]  cfg_sel = '1;
  logic [NC-1:0]     cfg_en = '0;
  logic [NC-1:0]     cfg_sat = '0;
  logic              snap_req = 1'b0;
  logic              clear_live = 1'b0;
  logic              rd_req = 1'b0;
  logic [IW-1:0]     rd_idx = '0;
  logic              rd_snap = 1'b0;
  logic              rd_clr = 1'b0;
  logic [NC-1:0]     ovf_clr = '0;
  logic              rd_ack;
  logic [CW-1:0]     rd_data;
  logic [NC-1:0]     ovf_flags;
  logic              ovf_irq;

  int n_checks = 0;
  int n_fail = 0;
  logic [CW-1:0] d;
  logic          a;

  cr_sa_counter_bank #(.N_CNT(NC), .CNT_W(CW), .N_EVT(NE), .SEL_W(SW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .stat_events(stat_events), .cfg_sel(cfg_sel), .cfg_en(cfg_en),
    .cfg_sat(cfg_sat), .snap_req(snap_req), .clear_live(clear_live), .rd_req(rd_req),
    .rd_idx(rd_idx), .rd_snap(rd_snap), .rd_clr(rd_clr), .ovf_clr(ovf_clr),
    .rd_ack(rd_ack), .rd_data(rd_data), .ovf_flags(ovf_flags), .ovf_irq(ovf_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int i, input int sel, input bit en, input bit sat);
    cfg_sel[i*SW +: SW] = SW'(sel);
    cfg_en[i]  = en;
    cfg_sat[i] = sat;
  endtask

  // Holds event bit b high for n cycles, then one cycle to let the last increment land.
  task automatic pulse_ev(input int b, input int n);
    stat_events[b] = 1'b1;
    repeat (n) tick();
    stat_events[b] = 1'b0;
    tick();
  endtask

  task automatic do_read(input int idx, input bit snap, input bit clr,
                         output logic [CW-1:0] dat, output logic ack);
    rd_req = 1'b1; rd_idx = IW'(idx); rd_snap = snap; rd_clr = clr;
    tick();
    ack = rd_ack; dat = rd_data;
    rd_req = 1'b0; rd_snap = 1'b0; rd_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%0d exp=0", rd_ack); end
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_data got=%0d exp=0", rd_data); end
    n_checks++; if (ovf_flags !== '0) begin n_fail++; $display("FAIL reset_flags got=%0h exp=0", ovf_flags); end
    n_checks++; if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%0d exp=0", ovf_irq); end
    rst = 1'b0;
    tick();
    do_read(0, 1'b0, 1'b0, d, a);
    n_checks++; if (a !== 1'b1 || d !== 8'd0) begin n_fail++; $display("FAIL reset_read ack=%0d data=%0d exp ack=1 data=0", a, d); end
  endtask

  task automatic test_basic_count();
    set_cfg(3, 5, 1'b1, 1'b0);
    set_cfg(4, 5, 1'b1, 1'b0);
    set_cfg(5, 5, 1'b0, 1'b0);
    pulse_ev(5, 10);
    n_checks++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_before got=%0d exp=0", rd_ack); end
    do_read(3, 1'b0, 1'b0, d, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL basic_ack got=%0d exp=1", a); end
    n_checks++; if (d !== 8'd10) begin n_fail++; $display("FAIL basic_data got=%0d exp=10", d); end
    n_checks++; if (ovf_flags !== '0) begin n_fail++; $display("FAIL basic_flags got=%0h exp=0", ovf_flags); end
    tick();
    n_checks++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_pulse got=%0d exp=0", rd_ack); end
    n_checks++; if (rd_data !== 8'd10) begin n_fail++; $display("FAIL basic_data_hold got=%0d exp=10", rd_data); end
    do_read(4, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd10) begin n_fail++; $display("FAIL shared_event got=%0d exp=10", d); end
    do_read(5, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd0) begin n_fail++; $display("FAIL disabled_cnt got=%0d exp=0", d); end
  endtask

  task automatic test_overflow();
    set_cfg(7, 10, 1'b1, 1'b1);
    pulse_ev(10, 254);
    do_read(7, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd254) begin n_fail++; $display("FAIL ovf_preload got=%0d exp=254", d); end
    pulse_ev(10, 1);
    do_read(7, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd255 || ovf_flags[7] !== 1'b0) begin n_fail++; $display("FAIL ovf_at_max data=%0d flag=%0d exp data=255 flag=0", d, ovf_flags[7]); end
    stat_events[10] = 1'b1; tick(); stat_events[10] = 1'b0; tick();
    n_checks++; if (ovf_flags[7] !== 1'b1) begin n_fail++; $display("FAIL sat_flag got=%0d exp=1", ovf_flags[7]); end
    n_checks++; if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag got=%0d exp=0", ovf_irq); end
    tick();
    n_checks++; if (ovf_irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got=%0d exp=1", ovf_irq); end
    pulse_ev(10, 1);
    do_read(7, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd255) begin n_fail++; $display("FAIL sat_hold got=%0d exp=255", d); end
    ovf_clr[7] = 1'b1; tick(); ovf_clr[7] = 1'b0;
    n_checks++; if (ovf_flags[7] !== 1'b0) begin n_fail++; $display("FAIL ovf_w1c got=%0d exp=0", ovf_flags[7]); end
    tick();
    n_checks++; if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%0d exp=0", ovf_irq); end
    cfg_sat[7] = 1'b0;
    pulse_ev(10, 1);
    n_checks++; if (ovf_flags[7] !== 1'b1) begin n_fail++; $display("FAIL wrap_flag got=%0d exp=1", ovf_flags[7]); end
    do_read(7, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd0) begin n_fail++; $display("FAIL wrap_zero got=%0d exp=0", d); end
    pulse_ev(10, 1);
    do_read(7, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd1) begin n_fail++; $display("FAIL wrap_one got=%0d exp=1", d); end
    pulse_ev(10, 254);
    stat_events[10] = 1'b1; tick(); stat_events[10] = 1'b0;
    ovf_clr[7] = 1'b1; tick(); ovf_clr[7] = 1'b0;
    n_checks++; if (ovf_flags[7] !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr got=%0d exp=1", ovf_flags[7]); end
    do_read(7, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd0) begin n_fail++; $display("FAIL wrap_again got=%0d exp=0", d); end
  endtask

  task automatic test_snap_clear();
    set_cfg(12, 20, 1'b1, 1'b0);
    pulse_ev(20, 20);
    stat_events[20] = 1'b1; tick(); stat_events[20] = 1'b0;
    snap_req = 1'b1; clear_live = 1'b1; tick(); snap_req = 1'b0; clear_live = 1'b0;
    do_read(12, 1'b1, 1'b0, d, a);
    n_checks++; if (d !== 8'd20) begin n_fail++; $display("FAIL snapclr_snap got=%0d exp=20", d); end
    do_read(12, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd0) begin n_fail++; $display("FAIL snapclr_live got=%0d exp=0", d); end
    do_read(3, 1'b1, 1'b0, d, a);
    n_checks++; if (d !== 8'd10) begin n_fail++; $display("FAIL snapclr_other_snap got=%0d exp=10", d); end
    do_read(3, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd0) begin n_fail++; $display("FAIL snapclr_other_live got=%0d exp=0", d); end
    pulse_ev(20, 2);
    stat_events[20] = 1'b1; tick(); stat_events[20] = 1'b0;
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    do_read(12, 1'b1, 1'b0, d, a);
    n_checks++; if (d !== 8'd2) begin n_fail++; $display("FAIL snap_excl_inc got=%0d exp=2", d); end
    do_read(12, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd3) begin n_fail++; $display("FAIL snap_live_inc got=%0d exp=3", d); end
    do_read(12, 1'b1, 1'b1, d, a);
    do_read(12, 1'b1, 1'b0, d, a);
    n_checks++; if (d !== 8'd2) begin n_fail++; $display("FAIL snap_rdclr_ignored got=%0d exp=2", d); end
    do_read(12, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd3) begin n_fail++; $display("FAIL snap_rdclr_live got=%0d exp=3", d); end
  endtask

  task automatic test_read_clear();
    set_cfg(20, 30, 1'b1, 1'b0);
    pulse_ev(30, 9);
    stat_events[30] = 1'b1; tick(); stat_events[30] = 1'b0;
    do_read(20, 1'b0, 1'b1, d, a);
    n_checks++; if (a !== 1'b1 || d !== 8'd9) begin n_fail++; $display("FAIL rdclr_data ack=%0d data=%0d exp ack=1 data=9", a, d); end
    do_read(20, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd1) begin n_fail++; $display("FAIL rdclr_keep_inc got=%0d exp=1", d); end
    do_read(20, 1'b0, 1'b1, d, a);
    do_read(20, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd0) begin n_fail++; $display("FAIL rdclr_plain got=%0d exp=0", d); end
  endtask

  task automatic test_back_to_back();
    set_cfg(21, 31, 1'b1, 1'b0);
    pulse_ev(31, 6);
    rd_req = 1'b1; rd_idx = IW'(21); rd_snap = 1'b0; tick();
    n_checks++; if (rd_ack !== 1'b1 || rd_data !== 8'd6) begin n_fail++; $display("FAIL b2b_first ack=%0d data=%0d exp ack=1 data=6", rd_ack, rd_data); end
    rd_idx = IW'(12); rd_snap = 1'b1; tick();
    n_checks++; if (rd_ack !== 1'b1 || rd_data !== 8'd2) begin n_fail++; $display("FAIL b2b_second ack=%0d data=%0d exp ack=1 data=2", rd_ack, rd_data); end
    rd_req = 1'b0; rd_snap = 1'b0; tick();
    n_checks++; if (rd_ack !== 1'b0 || rd_data !== 8'd2) begin n_fail++; $display("FAIL b2b_idle ack=%0d data=%0d exp ack=0 data=2", rd_ack, rd_data); end
  endtask

  task automatic test_reset_mid();
    set_cfg(25, 40, 1'b1, 1'b0);
    pulse_ev(40, 33);
    do_read(25, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd33) begin n_fail++; $display("FAIL mid_preload got=%0d exp=33", d); end
    rd_req = 1'b1; rd_idx = IW'(25);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rd_data !== 8'd0 || rd_ack !== 1'b0) begin n_fail++; $display("FAIL mid_async data=%0d ack=%0d exp data=0 ack=0", rd_data, rd_ack); end
    n_checks++; if (ovf_flags !== '0 || ovf_irq !== 1'b0) begin n_fail++; $display("FAIL mid_flags flags=%0h irq=%0d exp 0", ovf_flags, ovf_irq); end
    tick();
    n_checks++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL mid_no_ack got=%0d exp=0", rd_ack); end
    rst = 1'b0; rd_req = 1'b0;
    tick();
    do_read(25, 1'b0, 1'b0, d, a);
    n_checks++; if (a !== 1'b1 || d !== 8'd0) begin n_fail++; $display("FAIL mid_cnt_zero ack=%0d data=%0d exp ack=1 data=0", a, d); end
    do_read(12, 1'b1, 1'b0, d, a);
    n_checks++; if (d !== 8'd0) begin n_fail++; $display("FAIL mid_snap_zero got=%0d exp=0", d); end
    pulse_ev(40, 4);
    do_read(25, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd4) begin n_fail++; $display("FAIL mid_resume got=%0d exp=4", d); end
  endtask

  task automatic test_invalid();
    set_cfg(30, 127, 1'b1, 1'b0);
    set_cfg(31, 99, 1'b1, 1'b0);
    stat_events = '1;
    repeat (5) tick();
    stat_events = '0;
    tick();
    do_read(30, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd0) begin n_fail++; $display("FAIL sel_out_of_range got=%0d exp=0", d); end
    do_read(31, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd5) begin n_fail++; $display("FAIL sel_top_event got=%0d exp=5", d); end
    do_read(63, 1'b0, 1'b1, d, a);
    n_checks++; if (a !== 1'b1 || d !== 8'd0) begin n_fail++; $display("FAIL idx63 ack=%0d data=%0d exp ack=1 data=0", a, d); end
    do_read(31, 1'b0, 1'b0, d, a);
    do_read(40, 1'b0, 1'b0, d, a);
    n_checks++; if (a !== 1'b1 || d !== 8'd0) begin n_fail++; $display("FAIL idx40 ack=%0d data=%0d exp ack=1 data=0", a, d); end
    do_read(31, 1'b0, 1'b0, d, a);
    n_checks++; if (d !== 8'd5) begin n_fail++; $display("FAIL idx_oob_no_side got=%0d exp=5", d); end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_overflow();
    test_snap_clear();
    test_read_clear();
    test_back_to_back();
    test_reset_mid();
    test_invalid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cr_sa_counter_bank.md
Name: cr_sa_counter_bank

Overview:
- Parametrised statistics-aggregation counter bank for the CDDIP stats path; successor to the fixed 64 x 50-bit SA core.
- Each of N_CNT counters selects one of N_EVT single-bit event strobes and supports per-counter enable, wrap/saturate mode, sticky overflow and read-with-clear.
- Supports an atomic bank-wide snapshot.
- Sits between block stat_events buses and the SA regfile; the regfile accesses counters via a single-cycle-request read port.

Parameters:
- N_CNT, 64, number of counters
- CNT_W, 50, counter and snapshot width in bits
- N_EVT, 128, width of the stat_events input bus
- SEL_W, 7, event-select width per counter; requires 2**SEL_W >= N_EVT
- IDX_W, 6, read index width; requires 2**IDX_W >= N_CNT

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- stat_events  in  N_EVT  event strobes; each bit high = one occurrence this cycle
- cfg_sel  in  N_CNT*SEL_W  event select; counter i uses bits [i*SEL_W +: SEL_W]
- cfg_en  in  N_CNT  per-counter count enable
- cfg_sat  in  N_CNT  1 = saturate at max, 0 = wrap
- snap_req  in  1  pulse: copy all live counters into snapshot registers
- clear_live  in  1  pulse: zero all live counters
- rd_req  in  1  read request pulse
- rd_idx  in  IDX_W  counter index to read
- rd_snap  in  1  1 = read snapshot, 0 = read live counter
- rd_clr  in  1  with rd_req and rd_snap=0: clear the addressed live counter
- ovf_clr  in  N_CNT  W1C pulse per overflow flag
- rd_ack  out  1  read data valid, one-cycle pulse
- rd_data  out  CNT_W  read data
- ovf_flags  out  N_CNT  sticky overflow flags
- ovf_irq  out  1  registered OR of ovf_flags

Behaviour:
- Reset (async, rst=1): live counters, snapshots, event pipeline register, ovf_flags, rd_ack, rd_data and ovf_irq all go to 0. Reset asserted mid-read drops the read; no ack is issued.
- Event pipeline: stat_events registered into ev_q at edge E0. Counter i increments at edge E1 (next edge) if cfg_en[i]=1, cfg_sel[i] < N_EVT and ev_q[cfg_sel[i]]=1. cfg_sel/cfg_en are sampled at E1.
- cfg_sel >= N_EVT: counter never increments.
- Several counters may select the same event; all of them increment.
- Increment at max value (all ones):
  - cfg_sat=1: counter holds at max.
  - cfg_sat=0: counter wraps to 0.
  - In both modes ovf_flags[i] is set at the same edge.
- ovf_flags[i] cleared by ovf_clr[i]=1. A set and a clear in the same cycle: set wins.
- ovf_irq = registered |ovf_flags, so it lags the flags by one cycle.
- snap_req: all snapshots load the live values as they were before the edge; an increment in the same cycle is excluded from the snapshot but applied to the live counter.
- clear_live: all live counters go to 0; a coincident increment is dropped (clear wins).
- snap_req and clear_live together: atomic snap-and-clear. The snapshot holds the old values and the live counters become 0; no event is double-counted.
- Read:
  - rd_req at edge R0 gives rd_ack=1 and valid rd_data from R0 until the next edge; latency is 1 cycle.
  - rd_data is the source value before edge R0, and holds until the next read.
  - rd_req is accepted every cycle; back-to-back reads are legal.
  - rd_idx >= N_CNT: ack issued with rd_data = 0 and no side effects.
- Read-clear (rd_clr=1, rd_snap=0): the addressed counter is set to 0, plus 1 if an increment coincides, so no event is lost. The returned data is the pre-clear value.
- Read-clear vs bank-wide ops in the same cycle: clear_live dominates. snap_req still captures the pre-clear value.
- rd_clr with rd_snap=1: ignored; snapshots are never modified by reads.
- Arithmetic: unsigned, CNT_W bits, at most +1 per counter per cycle.

Test Plan:
- Reset, then cfg_sel[3]=5, cfg_en[3]=1; pulse stat_events[5] for 10 cycles, then read idx 3 -> rd_ack one cycle after rd_req, rd_data=10; ovf_flags=0.
- Counter 7 preloaded to 2**CNT_W-2 (via events, CNT_W=8 build) with cfg_sat=1; 3 events -> value 255 held, ovf_flags[7]=1 and ovf_irq=1 one cycle later. Repeat with cfg_sat=0 -> value 1 and flag set. Then ovf_clr[7] together with a new overflow -> flag stays 1.
- Counter at 20; snap_req and clear_live in the same cycle as an active event -> snapshot read=20, live read=0.
- Counter at 9; rd_req with rd_clr=1, rd_snap=0 coincident with an increment -> rd_data=9, subsequent live read=1.
- Assert rst mid-count at value 33 while rd_req is pending -> no rd_ack, all counters/flags/rd_data 0 immediately (asynchronous); counting resumes correctly after deassert.
- cfg_sel=127 with N_EVT=100, and rd_idx=63 with N_CNT=40 -> no increments; read acked with rd_data=0.
